// File: rtl/or_event_index_serializer.sv
// Snapshots an event vector and streams the index of each active line, lowest first, over valid/ready.
// Optional OR_EVENT_SYNC_EN adds a 2-flop synchroniser on Lines ahead of the snapshot.
module or_event_index_serializer #(
    parameter int          NR_OF_INPUTS = 14,
    parameter logic [15:0] BUBBLES_MASK = 16'h0000,
    parameter int          IDX_W        = 4
) (
    input  logic                    GlobalClock,
    input  logic                    Reset,
    input  logic [NR_OF_INPUTS-1:0] Lines,
    input  logic                    Capture,
    input  logic                    Ready,
    output logic                    Valid,
    output logic [IDX_W-1:0]        Index,
    output logic                    Any,
    output logic                    Busy,
    output logic                    Done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [NR_OF_INPUTS-1:0] pending_q, pending_d;
    logic                    any_q, any_d;
    logic                    done_q, done_d;
    logic [NR_OF_INPUTS-1:0] lines_s;
    logic [NR_OF_INPUTS-1:0] eff;
    logic [NR_OF_INPUTS-1:0] pending_next;
    logic [IDX_W-1:0]        idx;

`ifdef OR_EVENT_SYNC_EN
    logic [NR_OF_INPUTS-1:0] sync1_q, sync2_q;

    always_ff @(posedge GlobalClock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= Lines;
            sync2_q <= sync1_q;
        end
    end

    assign lines_s = sync2_q;
`else
    assign lines_s = Lines;
`endif

    assign eff = lines_s ^ BUBBLES_MASK[NR_OF_INPUTS-1:0];

    // Scan downward so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = NR_OF_INPUTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit is exactly the bit that idx points at.
    assign pending_next = pending_q & (pending_q - NR_OF_INPUTS'(1));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        any_d     = any_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Capture) begin
                    pending_d = eff;
                    any_d     = |eff;
                    if (|eff) begin
                        state_d = ST_EMIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (Ready) begin
                    pending_d = pending_next;
                    if (pending_next == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge GlobalClock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            any_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            any_q     <= any_d;
            done_q    <= done_d;
        end
    end

    assign Valid = (state_q == ST_EMIT);
    assign Busy  = (state_q == ST_EMIT);
    assign Index = idx;
    assign Any   = any_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_or_event_index_serializer.sv
// Directed bench: table of single-snapshot drains plus hand sequences for backpressure,
// inverted lines and mid-stream reset.
module tb_or_event_index_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] lines;
    logic        capture, capture_b, ready;
    logic        valid, any, busy, done;
    logic [3:0]  index;
    logic        valid_b, any_b, busy_b, done_b;
    logic [3:0]  index_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    or_event_index_serializer #(.NR_OF_INPUTS(14), .BUBBLES_MASK(16'h0000), .IDX_W(4)) dut (
        .GlobalClock(clk), .Reset(rst), .Lines(lines), .Capture(capture), .Ready(ready),
        .Valid(valid), .Index(index), .Any(any), .Busy(busy), .Done(done)
    );

    or_event_index_serializer #(.NR_OF_INPUTS(14), .BUBBLES_MASK(16'h3FFF), .IDX_W(4)) dut_b (
        .GlobalClock(clk), .Reset(rst), .Lines(lines), .Capture(capture_b), .Ready(ready),
        .Valid(valid_b), .Index(index_b), .Any(any_b), .Busy(busy_b), .Done(done_b)
    );

    typedef struct {
        logic [13:0] lines;
        int          cnt;
        logic        any;
        logic [63:0] exp;   // expected index j in nibble j
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        lines   = v.lines;
        capture = 1'b1;
        ready   = 1'b1;
        step();
        capture = 1'b0;
        lines   = ~v.lines;
        check("any", 32'(any), 32'(v.any));
        if (v.cnt == 0) begin
            check("empty_done", 32'(done), 32'd1);
            check("empty_valid", 32'(valid), 32'd0);
            step();
            check("empty_done_clr", 32'(done), 32'd0);
            check("empty_valid2", 32'(valid), 32'd0);
        end else begin
            for (int j = 0; j < v.cnt; j++) begin
                check("valid", 32'(valid), 32'd1);
                check("busy", 32'(busy), 32'd1);
                check("done_low", 32'(done), 32'd0);
                check("index", 32'(index), 32'(v.exp[4*j +: 4]));
                step();
            end
            check("drain_done", 32'(done), 32'd1);
            check("drain_valid", 32'(valid), 32'd0);
            check("drain_busy", 32'(busy), 32'd0);
            step();
            check("done_pulse", 32'(done), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{lines: 14'h0005, cnt: 2,  any: 1'b1, exp: 64'h20};
        vecs[1] = '{lines: 14'h0000, cnt: 0,  any: 1'b0, exp: 64'h0};
        vecs[2] = '{lines: 14'h3FFF, cnt: 14, any: 1'b1, exp: 64'hDCBA9876543210};
        vecs[3] = '{lines: 14'h1248, cnt: 4,  any: 1'b1, exp: 64'hC963};
        vecs[4] = '{lines: 14'h0A00, cnt: 2,  any: 1'b1, exp: 64'hB9};

        rst = 1'b1; lines = '0; capture = 1'b0; capture_b = 1'b0; ready = 1'b0;
        step();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_any", 32'(any), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure with an ignored Capture while busy.
        lines = 14'h2000; capture = 1'b1; ready = 1'b0;
        step();
        capture = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_index", 32'(index), 32'd13);
            capture = (c == 2);
            lines   = 14'h0001;
            step();
        end
        capture = 1'b0;
        check("bp_valid_end", 32'(valid), 32'd1);
        check("bp_index_end", 32'(index), 32'd13);
        ready = 1'b1;
        step();
        check("bp_done", 32'(done), 32'd1);
        check("bp_valid_off", 32'(valid), 32'd0);
        step();
        check("bp_done_clr", 32'(done), 32'd0);
        check("bp_no_extra", 32'(valid), 32'd0);
        check("bp_any_hold", 32'(any), 32'd1);

        // Inverted lines: only line 0 is effectively active.
        lines = 14'h3FFE; capture_b = 1'b1; ready = 1'b1;
        step();
        capture_b = 1'b0;
        check("inv_valid", 32'(valid_b), 32'd1);
        check("inv_index", 32'(index_b), 32'd0);
        check("inv_any", 32'(any_b), 32'd1);
        step();
        check("inv_done", 32'(done_b), 32'd1);
        check("inv_valid_off", 32'(valid_b), 32'd0);

        // Mid-stream reset after Index=5 has been presented.
        step();
        lines = 14'h3FFF; capture = 1'b1; ready = 1'b1;
        step();
        capture = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check("abort_index5", 32'(index), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_index", 32'(index), 32'd0);
        check("abort_any", 32'(any), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("abort_no_done", 32'(done), 32'd0);
        lines = 14'h0030; capture = 1'b1;
        step();
        capture = 1'b0;
        check("restart_valid", 32'(valid), 32'd1);
        check("restart_index", 32'(index), 32'd4);
        step();
        check("restart_index2", 32'(index), 32'd5);
        step();
        check("restart_done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
